dmem_responder: RTL and testbench

Data-memory responder on the far side of the core's load/store port. It accepts one request at a time from the memory-access stage, performs byte, halfword or word reads and writes on an internal word-organised array, and returns load data after a programmable latency with a valid/ready handshake. It also reports misaligned, reserved-width and out-of-range accesses instead of completing them silently.

---
 rtl/rv_mem_pkg.sv | 26 ++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/rv_mem_pkg.sv
// Shared load/store encodings, address constants and responder FSM states.
package rv_mem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_RSV  = 2'b11;

    localparam logic [31:0] DMEM_BASE_DEF = 32'h1001_0000;
    localparam logic [31:0] MMIO_TX_ADDR  = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  width;
        logic        uns;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the memory-access stage (master) and the data memory (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic        req_uns;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_width, req_uns, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_width, req_uns, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for sub-word accesses: write enables/replicated data, load extract/extend.
module dmem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  width,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [31:0] rshift;

    always_comb begin
        be       = 4'b0000;
        wdata_sh = wdata;
        rdata    = 32'h0;
        misalign = 1'b0;
        rshift   = rword >> {addr_lo, 3'b000};
        case (width)
            W_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wdata_sh = {4{wdata[7:0]}};
                rdata    = {{24{rshift[7] & ~uns}}, rshift[7:0]};
            end
            W_HALF: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                rdata    = {{16{rshift[15] & ~uns}}, rshift[15:0]};
            end
            W_WORD: begin
                misalign = (addr_lo != 2'b00);
                be       = 4'b1111;
                rdata    = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed latency, faults on bad accesses.
// Optional DMEM_MMIO_EN adds a byte-wide transmit register at MMIO_TX_ADDR.
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter logic [31:0] BASE    = DMEM_BASE_DEF,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_responder_if.slave bus
`ifdef DMEM_MMIO_EN
    ,
    output logic           mmio_tx_valid,
    output logic [7:0]     mmio_tx_data
`endif
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);

    dmem_state_e   state, state_d;
    logic [CW-1:0] cnt;
    dmem_req_t     req_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          oor;
    logic          fault;
    logic          is_mmio;
    logic          do_access;
    logic [3:0]    be;
    logic [31:0]   wdata_sh;
    logic [31:0]   rdata_ext;
    logic          misalign;

    // Addresses below BASE wrap to huge offsets, so one unsigned compare covers both ends.
    assign off = req_q.addr - BASE;
    assign idx = off[AW+1:2];
    assign oor = (off >= SPAN);

`ifdef DMEM_MMIO_EN
    assign is_mmio = (req_q.addr == MMIO_TX_ADDR);
    assign fault   = (req_q.width == W_RSV) | misalign | (is_mmio ? (req_q.width != W_BYTE) : oor);
`else
    assign is_mmio = 1'b0;
    assign fault   = (req_q.width == W_RSV) | misalign | oor;
`endif

    assign do_access = (state == BUSY) && (cnt == '0);

    dmem_lane_align u_align (
        .addr_lo  (req_q.addr[1:0]),
        .width    (req_q.width),
        .uns      (req_q.uns),
        .wdata    (req_q.wdata),
        .rword    (mem[idx]),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (rdata_ext),
        .misalign (misalign)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.req_valid) state_d = BUSY;
            BUSY:    if (cnt == '0) state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && bus.req_valid) begin
                req_q <= '{we: bus.req_we, addr: bus.req_addr, width: bus.req_width,
                           uns: bus.req_uns, wdata: bus.req_wdata};
                cnt   <= CNT_INIT;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (do_access) begin
                rdata_q <= (fault || req_q.we || is_mmio) ? 32'h0 : rdata_ext;
                err_q   <= fault;
            end
        end
    end

    // Array is never cleared; reset only suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!rst && do_access && req_q.we && !fault && !is_mmio) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) mem[idx][l*8 +: 8] <= wdata_sh[l*8 +: 8];
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_tx_valid <= 1'b0;
            mmio_tx_data  <= 8'h00;
        end else begin
            mmio_tx_valid <= do_access && req_q.we && is_mmio && !fault;
            if (do_access && req_q.we && is_mmio && !fault)
                mmio_tx_data <= req_q.wdata[7:0];
        end
    end
`endif

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected {rdata,err} queued at issue, popped at response.
module tb_dmem_responder;
    import rv_mem_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus ();

`ifdef DMEM_MMIO_EN
    logic       mmio_tx_valid;
    logic [7:0] mmio_tx_data;
    int         mmio_cnt = 0;
    logic [7:0] mmio_last = 8'h00;
    always @(posedge clk) if (mmio_tx_valid) begin
        mmio_cnt  = mmio_cnt + 1;
        mmio_last = mmio_tx_data;
    end
`endif

    dmem_responder #(.BASE(32'h1001_0000), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_MMIO_EN
        ,
        .mmio_tx_valid (mmio_tx_valid),
        .mmio_tx_data  (mmio_tx_data)
`endif
    );

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check latency, optional backpressure, then score the response.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] width, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int   k;
        exp_t e;
        logic [31:0] r0;
        k = 0;
        while (!bus.req_ready && k < 20) begin tick(); k++; end
        chk({tag, " rdy"}, 32'(bus.req_ready), 32'd1);
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_width = width;
        bus.req_uns   = uns;
        bus.req_wdata = wdata;
        tick();
        // Scramble inputs after acceptance; the latched request must be unaffected.
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = $urandom;
        bus.req_width = ~width;
        bus.req_uns   = ~uns;
        bus.req_wdata = $urandom;
        k = 0;
        while (!bus.resp_valid && k < 20) begin tick(); k++; end
        chk({tag, " lat"}, 32'(k), 32'(LAT));
        r0 = bus.resp_rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold"}, {bus.resp_rdata, 31'(0), bus.resp_valid} == {r0, 31'(0), 1'b1}
                                && !bus.req_ready ? 32'd1 : 32'd0, 32'd1);
        end
        e = sb_q.pop_front();
        chk({tag, " rdata"}, bus.resp_rdata, e.rdata);
        chk({tag, " err"}, 32'(bus.resp_err), 32'(e.err));
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk({tag, " idle"}, {30'(0), bus.req_ready, bus.resp_valid}, 32'b10);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_width  = W_WORD;
        bus.req_uns    = 1'b0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;  // ignored outside RESP
        rst = 1'b1;
        tick(); tick();
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err",   32'(bus.resp_err), 32'd0);
        rst = 1'b0;
        tick();
        bus.resp_ready = 1'b0;

        do_req("st_w",   1, 32'h1001_0004, W_WORD, 0, 32'hDEAD_BEEF, 32'h0, 0, 0);
        do_req("ld_w",   0, 32'h1001_0004, W_WORD, 0, 32'h0, 32'hDEAD_BEEF, 0, 0);
        do_req("st_b",   1, 32'h1001_0006, W_BYTE, 0, 32'h1234_5680, 32'h0, 0, 0);
        do_req("ld_bs",  0, 32'h1001_0006, W_BYTE, 0, 32'h0, 32'hFFFF_FF80, 0, 0);
        do_req("ld_bu",  0, 32'h1001_0006, W_BYTE, 1, 32'h0, 32'h0000_0080, 0, 0);
        do_req("ld_w2",  0, 32'h1001_0004, W_WORD, 1, 32'h0, 32'hDE80_BEEF, 0, 0);
        do_req("st_w2",  1, 32'h1001_0004, W_WORD, 0, 32'h8001_1234, 32'h0, 0, 0);
        do_req("ld_hs",  0, 32'h1001_0006, W_HALF, 0, 32'h0, 32'hFFFF_8001, 0, 0);
        do_req("ld_hu",  0, 32'h1001_0004, W_HALF, 1, 32'h0, 32'h0000_1234, 0, 0);
        do_req("st_hm",  1, 32'h1001_0005, W_HALF, 0, 32'h0000_FFFF, 32'h0, 1, 0);
        do_req("ld_w3",  0, 32'h1001_0004, W_WORD, 0, 32'h0, 32'h8001_1234, 0, 0);
        do_req("ld_wm",  0, 32'h1001_0006, W_WORD, 0, 32'h0, 32'h0, 1, 0);
        do_req("ld_lo",  0, 32'h1000_FFFC, W_WORD, 0, 32'h0, 32'h0, 1, 0);
        do_req("ld_hi",  0, 32'h1001_0000 + DEPTH*4, W_WORD, 0, 32'h0, 32'h0, 1, 0);
        do_req("st_hi",  1, 32'h1001_0000 + DEPTH*4, W_WORD, 0, 32'h5555_5555, 32'h0, 1, 0);
        do_req("st_top", 1, 32'h1001_0000 + DEPTH*4 - 4, W_WORD, 0, 32'hAABB_CCDD, 32'h0, 0, 0);
        do_req("ld_top", 0, 32'h1001_0000 + DEPTH*4 - 4, W_WORD, 0, 32'h0, 32'hAABB_CCDD, 0, 0);
        do_req("ld_rsv", 0, 32'h1001_0004, W_RSV, 0, 32'h0, 32'h0, 1, 0);
        do_req("ld_bp",  0, 32'h1001_0004, W_WORD, 0, 32'h0, 32'h8001_1234, 0, 5);
        do_req("st_old", 1, 32'h1001_0008, W_WORD, 0, 32'hCAFE_F00D, 32'h0, 0, 0);

        // Reset on the edge where the store would have been performed.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h1001_0008;
        bus.req_width = W_WORD; bus.req_uns = 1'b0; bus.req_wdata = 32'h1234_5678;
        tick();
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rstb_valid", 32'(bus.resp_valid), 32'd0);
        chk("rstb_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        tick();
        do_req("ld_old", 0, 32'h1001_0008, W_WORD, 0, 32'h0, 32'hCAFE_F00D, 0, 0);

`ifdef DMEM_MMIO_EN
        do_req("mmio_st", 1, 32'hFFFF_0000, W_BYTE, 0, 32'h0000_0041, 32'h0, 0, 0);
        chk("mmio_cnt",  32'(mmio_cnt), 32'd1);
        chk("mmio_data", 32'(mmio_last), 32'h41);
        do_req("mmio_ld", 0, 32'hFFFF_0000, W_BYTE, 0, 32'h0, 32'h0, 0, 0);
        do_req("mmio_sw", 1, 32'hFFFF_0000, W_WORD, 0, 32'h0, 32'h0, 1, 0);
        chk("mmio_cnt2", 32'(mmio_cnt), 32'd1);
`else
        do_req("mmio_st", 1, 32'hFFFF_0000, W_BYTE, 0, 32'h0000_0041, 32'h0, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
